// File: rtl/psum_collector_pkg.sv
// psum_collector_pkg: shared FSM state type and default widths
// for the partial-sum collector and its de-skew stage.
package psum_collector_pkg;

  localparam int DEF_DATA_WIDTH         = 20;
  localparam int DEF_A_TILE_ROW_SIZE    = 16;
  localparam int DEF_W_TILE_COLUMN_SIZE = 2;
  localparam int DEF_ACC_WIDTH          = 48;
  localparam int TILE_CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LAST  = 2'd2
  } psum_state_e;

endpackage

// File: rtl/psum_deskew.sv
// psum_deskew: realigns a skewed PE-array output row.
// Ports: clk, rst (sync, high), in_valid/in_sum (column j
// arrives j cycles late), out_valid/out_sum (all aligned).
module psum_deskew #(
  parameter int width   = 40,
  parameter int columns = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [width*columns-1:0] in_sum,
  output logic                     out_valid,
  output logic [width*columns-1:0] out_sum
);

  generate
    if (columns == 1) begin : g_vnone
      assign out_valid = in_valid;
    end else begin : g_vpipe
      logic [columns-2:0] vp;
      always_ff @(posedge clk) begin
        if (rst) begin
          vp <= '0;
        end else begin
          vp[0] <= in_valid;
          for (int k = 1; k < columns - 1; k++)
            vp[k] <= vp[k-1];
        end
      end
      assign out_valid = vp[columns-2];
    end

    // Column j waits columns-1-j cycles; the last column
    // arrives aligned and passes straight through.
    for (genvar j = 0; j < columns; j++) begin : g_col
      localparam int D = columns - 1 - j;
      if (D == 0) begin : g_pass
        assign out_sum[j*width +: width] =
          in_sum[j*width +: width];
      end else begin : g_dly
        logic [width-1:0] pipe [D];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int k = 0; k < D; k++)
              pipe[k] <= '0;
          end else begin
            pipe[0] <= in_sum[j*width +: width];
            for (int k = 1; k < D; k++)
              pipe[k] <= pipe[k-1];
          end
        end
        assign out_sum[j*width +: width] = pipe[D-1];
      end
    end
  endgenerate

endmodule

// File: rtl/psum_collector.sv
// psum_collector: accumulates skewed PE partial sums over
// num_tiles passes and emits one finished row per valid row.
// Ports: clk, rst (sync, high), start, num_tiles, in_valid,
// in_sum -> busy, out_valid, out_data, done, err (sticky).
// Define PSUM_SAT_EN to saturate each output column to the
// signed 2*data_width range instead of wrapping.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int data_width         = DEF_DATA_WIDTH,
  parameter int a_tile_row_size    = DEF_A_TILE_ROW_SIZE,
  parameter int w_tile_column_size = DEF_W_TILE_COLUMN_SIZE,
  parameter int acc_width          = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_tiles,
  input  logic                  in_valid,
  input  logic [2*data_width*w_tile_column_size-1:0] in_sum,
  output logic                  busy,
  output logic                  out_valid,
  output logic [2*data_width*w_tile_column_size-1:0] out_data,
  output logic                  done,
  output logic                  err
);

  localparam int PW = 2 * data_width;
  localparam int C  = w_tile_column_size;
  localparam int R  = a_tile_row_size;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  psum_state_e           state;
  logic                  idle;
  logic                  accept;
  logic                  dv;
  logic [PW*C-1:0]       ds;
  logic [RW-1:0]         row_cnt;
  logic [TILE_CNT_W-1:0] tile_cnt;
  logic [TILE_CNT_W-1:0] last_tile;
  logic                  row_end;
  logic                  out_last;
  logic [PW*C-1:0]       row_res;

  assign idle    = (state == ST_IDLE);
  assign busy    = !idle;
  assign accept  = start && idle;
  assign row_end = dv && (row_cnt == RW'(R - 1));

  // Rows offered while idle never enter the skew pipe.
  psum_deskew #(
    .width   (PW),
    .columns (C)
  ) u_deskew (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !idle),
    .in_sum    (in_sum),
    .out_valid (dv),
    .out_sum   (ds)
  );

  generate
    for (genvar j = 0; j < C; j++) begin : g_col
      logic signed [acc_width-1:0] acc [R];
      logic signed [acc_width-1:0] sx;
      logic signed [acc_width-1:0] base;
      logic signed [acc_width-1:0] total;
      logic [PW-1:0]               res;

      assign sx    = acc_width'(signed'(ds[j*PW +: PW]));
      // Pass 0 starts from zero, so the same sum
      // both overwrites and accumulates.
      assign base  = (tile_cnt == '0) ? '0 : acc[row_cnt];
      assign total = base + sx;

      always_ff @(posedge clk) begin
        if (dv && state == ST_ACCUM)
          acc[row_cnt] <= total;
      end

`ifdef PSUM_SAT_EN
      logic [acc_width-PW:0] hi;
      assign hi = total[acc_width-1:PW-1];
      always_comb begin
        res = total[PW-1:0];
        if (!(&hi || ~|hi))
          res = total[acc_width-1]
              ? {1'b1, {(PW-1){1'b0}}}
              : {1'b0, {(PW-1){1'b1}}};
      end
`else
      assign res = total[PW-1:0];
`endif

      assign row_res[j*PW +: PW] = res;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      tile_cnt  <= '0;
      last_tile <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;

      if (accept) begin
        err       <= 1'b0;
        row_cnt   <= '0;
        tile_cnt  <= '0;
        last_tile <= (num_tiles == 8'd0)
                   ? 8'd0 : num_tiles - 8'd1;
        state     <= (num_tiles > 8'd1)
                   ? ST_ACCUM : ST_LAST;
      end else if (in_valid && idle) begin
        err <= 1'b1;
      end

      if (dv && !idle) begin
        row_cnt <= row_end ? '0 : row_cnt + RW'(1);
        if (row_end)
          tile_cnt <= tile_cnt + 8'd1;
        if (state == ST_ACCUM && row_end &&
            tile_cnt + 8'd1 == last_tile)
          state <= ST_LAST;
        if (state == ST_LAST) begin
          out_valid <= 1'b1;
          out_data  <= row_res;
          out_last  <= row_end;
        end
      end

      // Final row left last cycle: finish the job.
      if (out_valid && out_last) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: randomized scoreboard bench for
// psum_collector with a per-job arithmetic reference model.
module tb_psum_collector;

  localparam int PW = 40;
  localparam int C  = 2;
  localparam int R  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    num_tiles;
  logic          in_valid;
  logic [PW*C-1:0] in_sum;
  logic          busy;
  logic          out_valid;
  logic [PW*C-1:0] out_data;
  logic          done;
  logic          err;

  psum_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_tiles (num_tiles),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW*C-1:0] exp_q[$];
  int              cyc_q[$];
  int              out_cnt      = 0;
  int              done_cnt     = 0;
  int              last_out_cyc = -10;
  logic [PW*C-1:0] last_out     = '0;

  task automatic chk(string nm, logic [79:0] act,
                     logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic longint sx(logic [39:0] v);
    logic signed [39:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic logic [39:0] fin(longint v);
    longint t;
    t = v;
`ifdef PSUM_SAT_EN
    if (t > (longint'(1) <<< 39) - 1)
      t = (longint'(1) <<< 39) - 1;
    else if (t < -(longint'(1) <<< 39))
      t = -(longint'(1) <<< 39);
`endif
    return t[39:0];
  endfunction

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  // Monitor: pops the scoreboard on every output row.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        out_cnt++;
        last_out_cyc = cyc;
        last_out     = out_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%h required=none",
                   out_data);
        end else begin
          chk("row_data", out_data, exp_q.pop_front());
          chk("row_latency", 80'(cyc), 80'(cyc_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        chk("done_after_last", 80'(cyc), 80'(last_out_cyc + 1));
      end
    end
  end

  task automatic drive(bit v, logic [39:0] c0,
                       logic [39:0] c1, bit st);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sum   = {c1, c0};
    start    = st;
    if (st) num_tiles = 8'd1;
  endtask

  // mode 0 random, 1 rows {1,2}, 2 max positive,
  // 3 random with first row {5,-3}
  task automatic run_job(int n, int mode, int abort_row,
                         bit poke);
    int          np;
    int          g;
    int          oc0;
    int          dc0;
    logic [39:0] nxt1;
    logic [39:0] dat [4][R][C];
    longint      accm [R][C];
    np  = (n == 0) ? 1 : n;
    g   = 0;
    oc0 = out_cnt;
    dc0 = done_cnt;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        accm[r][c] = 0;
    for (int p = 0; p < np; p++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          case (mode)
            1:       dat[p][r][c] = 40'(c + 1);
            2:       dat[p][r][c] = 40'h7FFFFFFFFF;
            default: dat[p][r][c] = rnd40();
          endcase
          if (mode == 3 && p == 0 && r == 0)
            dat[p][r][c] = (c == 0) ? 40'd5 : -40'sd3;
          accm[r][c] += sx(dat[p][r][c]);
        end

    @(posedge clk);
    #1;
    start     = 1'b1;
    num_tiles = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_clear_on_start", err, 0);
    chk("busy_after_start", busy, 1);

    nxt1 = rnd40();
    for (int p = 0; p < np; p++)
      for (int r = 0; r < R; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, rnd40(), nxt1, 1'b0);
          nxt1 = rnd40();
        end
        drive(1'b1, dat[p][r][0], nxt1,
              poke && p == 0 && r == 3);
        nxt1 = dat[p][r][1];
        if (p == np - 1) begin
          exp_q.push_back({fin(accm[r][1]), fin(accm[r][0])});
          cyc_q.push_back(cyc + 2);
        end
        if (g == abort_row) begin
          drive(1'b0, rnd40(), nxt1, 1'b0);
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          chk("busy_in_rst", busy, 0);
          chk("outv_in_rst", out_valid, 0);
          @(posedge clk);
          #1;
          rst = 1'b0;
          exp_q.delete();
          cyc_q.delete();
          repeat (6) @(negedge clk);
          chk("busy_after_abort", busy, 0);
          return;
        end
        g++;
      end
    drive(1'b0, rnd40(), nxt1, 1'b0);

    for (int i = 0; i < 60 && done_cnt == dc0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_count", 80'(done_cnt - dc0), 80'd1);
    chk("out_count", 80'(out_cnt - oc0), 80'(R));
    chk("queue_empty", 80'(exp_q.size()), 80'd0);
  endtask

  logic [39:0] big_exp;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    num_tiles = 8'd0;
    in_sum    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_job(1, 3, -1, 1'b0);

    run_job(3, 1, -1, 1'b0);
    chk("three_pass_row", last_out, {40'd6, 40'd3});

    run_job(2, 2, -1, 1'b0);
`ifdef PSUM_SAT_EN
    big_exp = 40'h7FFFFFFFFF;
`else
    big_exp = 40'hFFFFFFFFFE;
`endif
    chk("big_sum_col0", last_out[39:0], big_exp);

    drive(1'b1, rnd40(), rnd40(), 1'b0);
    drive(1'b0, rnd40(), rnd40(), 1'b0);
    @(negedge clk);
    chk("err_set", err, 1);
    chk("busy_idle_valid", busy, 0);
    repeat (4) @(negedge clk);
    run_job(1, 0, -1, 1'b0);

    run_job(3, 0, R + 5, 1'b0);
    run_job(1, 0, -1, 1'b0);

    for (int i = 0; i < 6; i++)
      run_job($urandom_range(0, 4), 0, -1, i == 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
